// File: rtl/snn_memory_loader.sv
// Loads the SNN weight/delay memory word by word from a slow pin strobe.
// Optional trailer checksum check is enabled by defining LOADER_CHECKSUM_EN.
module snn_memory_loader #(
    parameter int M = 320,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [N-1:0]         byte_in,
    output logic [$clog2(M)-1:0] mem_addr,
    output logic [N-1:0]         mem_data,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic                 checksum_err
);

    localparam int A = $clog2(M);
    localparam logic [A-1:0] LAST = A'(M - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic s1, s2, s3;
    logic strobe_edge;
    logic [A-1:0] count;
    logic do_clear, do_write, do_check;

    // Synchroniser and history flop run in every state so a level already
    // high when a load starts cannot produce a second edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= byte_valid;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign strobe_edge = s2 & ~s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_clear   = 1'b0;
        do_write   = 1'b0;
        do_check   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end
            end
            LOAD: begin
                // start takes priority; a coincident word is dropped
                if (start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end else if (strobe_edge) begin
                    do_write = 1'b1;
                    if (count == LAST) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end else if (strobe_edge) begin
                    do_check   = 1'b1;
                    next_state = DONE;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (do_clear) begin
                count <= '0;
            end else if (do_write) begin
                mem_addr <= count;
                mem_data <= byte_in;
                mem_we   <= 1'b1;
                if (count != LAST) count <= count + A'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [N-1:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            checksum_err <= 1'b0;
        end else begin
            if (do_clear) begin
                acc          <= '0;
                checksum_err <= 1'b0;
            end else if (do_write) begin
                acc <= acc + byte_in;
            end else if (do_check) begin
                checksum_err <= (byte_in != acc);
            end
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

    assign busy = (state == LOAD) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_snn_memory_loader.sv
// Directed bench for snn_memory_loader with M=4, N=8; the checksum section
// is active when LOADER_CHECKSUM_EN is defined.
module tb_snn_memory_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic [1:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       checksum_err;

    int vectors = 0;
    int miscompares = 0;

    snn_memory_loader #(.M(4), .N(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_in(byte_in),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .busy(busy),
        .done(done),
        .checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
    endtask

    // One pin strobe: high for 4 clocks, low for 4. start_at>0 raises start
    // at that negedge so it coincides with the detected edge (start_at=2).
    task automatic send(input string tag, input logic [7:0] b, input bit exp_we,
                        input logic [1:0] exp_addr, input int start_at);
        logic [1:0] a0;
        logic [7:0] d0;
        logic [1:0] ga;
        logic [7:0] gd;
        int wes;
        int pos;
        a0 = mem_addr;
        d0 = mem_data;
        ga = '0;
        gd = '0;
        wes = 0;
        pos = 0;
        @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wes++;
                pos = i;
                ga = mem_addr;
                gd = mem_data;
            end
            start = (start_at != 0 && i == start_at);
            if (i == 4) byte_valid = 1'b0;
        end
        start = 1'b0;
        if (exp_we) begin
            check({tag, "_we_count"}, wes, 1);
            check({tag, "_we_latency"}, pos, 3);
            check({tag, "_addr"}, ga, exp_addr);
            check({tag, "_data"}, gd, b);
        end else begin
            check({tag, "_no_we"}, wes, 0);
            check({tag, "_addr_held"}, mem_addr, a0);
            check({tag, "_data_held"}, mem_data, d0);
        end
    endtask

    // Completes a load: with the checksum feature the trailer is sent first.
    task automatic end_load(input string tag, input logic [7:0] sum);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_busy_before_trailer"}, busy, 1);
        send({tag, "_trailer"}, sum, 1'b0, 2'd0, 0);
        check({tag, "_chk_err"}, checksum_err, 0);
`endif
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chk_err", checksum_err, 0);
        reset = 1'b0;

        send("pre_start", 8'h5A, 1'b0, 2'd0, 0);
        check("pre_start_busy", busy, 0);

        // Basic fill
        pulse_start();
        send("fill0", 8'h11, 1'b1, 2'd0, 0);
        send("fill1", 8'h22, 1'b1, 2'd1, 0);
        send("fill2", 8'h33, 1'b1, 2'd2, 0);
        send("fill3", 8'h44, 1'b1, 2'd3, 0);
        end_load("fill", 8'hAA);
        send("post_done", 8'h99, 1'b0, 2'd0, 0);
        check("post_done_still_done", done, 1);

        // Restart in the middle of a load
        pulse_start();
        send("pre_restart0", 8'h55, 1'b1, 2'd0, 0);
        send("pre_restart1", 8'h66, 1'b1, 2'd1, 0);
        pulse_start();
        send("restart0", 8'hA0, 1'b1, 2'd0, 0);
        send("restart1", 8'hA1, 1'b1, 2'd1, 0);
        send("restart2", 8'hA2, 1'b1, 2'd2, 0);
        send("restart3", 8'hA3, 1'b1, 2'd3, 0);
        end_load("restart", 8'h86);

        // start coinciding with a detected edge drops that word
        pulse_start();
        send("coll_pre0", 8'h10, 1'b1, 2'd0, 0);
        send("coll_pre1", 8'h20, 1'b1, 2'd1, 0);
        send("coll_drop", 8'h77, 1'b0, 2'd0, 2);
        check("coll_busy", busy, 1);
        send("coll0", 8'h88, 1'b1, 2'd0, 0);
        send("coll1", 8'h99, 1'b1, 2'd1, 0);
        send("coll2", 8'hAA, 1'b1, 2'd2, 0);
        send("coll3", 8'hBB, 1'b1, 2'd3, 0);
        end_load("coll", 8'h86);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send("cs_w0", 8'h01, 1'b1, 2'd0, 0);
        send("cs_w1", 8'h02, 1'b1, 2'd1, 0);
        send("cs_w2", 8'h03, 1'b1, 2'd2, 0);
        send("cs_w3", 8'h04, 1'b1, 2'd3, 0);
        send("cs_good_trailer", 8'h0A, 1'b0, 2'd0, 0);
        check("cs_good_err", checksum_err, 0);
        check("cs_good_done", done, 1);
        pulse_start();
        send("cs_w0b", 8'h01, 1'b1, 2'd0, 0);
        send("cs_w1b", 8'h02, 1'b1, 2'd1, 0);
        send("cs_w2b", 8'h03, 1'b1, 2'd2, 0);
        send("cs_w3b", 8'h04, 1'b1, 2'd3, 0);
        send("cs_bad_trailer", 8'h0B, 1'b0, 2'd0, 0);
        check("cs_bad_err", checksum_err, 1);
        check("cs_bad_done", done, 1);
        pulse_start();
        check("cs_err_cleared", checksum_err, 0);
`endif

        // Asynchronous reset while a write is on the port
        pulse_start();
        send("rl0", 8'h31, 1'b1, 2'd0, 0);
        send("rl1", 8'h32, 1'b1, 2'd1, 0);
        @(negedge clk);
        byte_in = 8'h33;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rl2_we_before_reset", mem_we, 1);
        check("rl2_addr_before_reset", mem_addr, 2);
        #1 reset = 1'b1;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_data", mem_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_chk_err", checksum_err, 0);
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        send("after_arst", 8'h44, 1'b0, 2'd0, 0);
        check("after_arst_busy", busy, 0);
        pulse_start();
        send("after_arst_load0", 8'hC3, 1'b1, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snn_memory_loader.md
# snn_memory_loader

Sequential writer that fills the SNN weight/delay memory from an external byte stream. It synchronises a slow strobe from the chip pins and captures one N-bit word per strobe. Each word is written through the memory's single write port (address, data, write enable) at auto-incrementing addresses 0..M-1. It sits between the top-level input pins and the memory, and reports busy/done so the network core stays idle until configuration is complete.

## Interface
- M, 320, number of memory words to load; address width is $clog2(M)
- N, 8, word width in bits
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  synchronous pulse; begins or restarts a load at address 0
- byte_valid  input  1  asynchronous strobe from pin; each rising edge delivers one word
- byte_in  input  N  word on pins; stable from byte_valid rise until byte_valid fall
- mem_addr  output  $clog2(M)  write address to memory
- mem_data  output  N  write data to memory
- mem_we  output  1  one-cycle write enable to memory
- busy  output  1  high while in LOAD or CHECK
- done  output  1  high in DONE until next start
- checksum_err  output  1  checksum mismatch flag (LOADER_CHECKSUM_EN only; else 0)

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE. Reset enters IDLE.
- Strobe path: byte_valid goes through 2-flop synchroniser s1→s2, then history flop s3; edge = s2 & ~s3.
- IDLE: on start, go to LOAD. Clear word counter, next address and checksum accumulator.
- LOAD, on edge:
  - Register mem_data <= byte_in, mem_addr <= counter, mem_we <= 1 for one cycle.
  - Increment counter and add byte_in to accumulator (mod 2^N).
- LOAD exit: after the write of word M-1, go to CHECK if the macro is defined, else DONE.
- CHECK: the next edge captures byte_in as the expected checksum. No memory write. Set checksum_err = (byte_in != accumulator) and go to DONE.
- DONE: done=1; edges ignored. A start pulse goes to LOAD and clears done and checksum_err.
- Edges in IDLE and DONE are ignored with no write.
- start in LOAD/CHECK restarts: counter=0, accumulator=0, state LOAD, no write that cycle. start and edge in the same cycle: start wins and the word is dropped.
- Counter never exceeds M-1; no address wrap. Extra edges after word M-1 (no macro) land in DONE and are ignored.
- Synchroniser flops keep running in every state, so an edge already high at start is not seen twice.

## Timing
- Reset values: mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, checksum_err=0, s1/s2/s3=0, state IDLE.
- Latency: byte_valid rises before clock edge k, s1=1 after k, s2=1 after k+1, edge high during cycle k+1→k+2. The memory write happens at edge k+3.
- mem_we is exactly one cycle wide per accepted word. mem_addr and mem_data are held until the next write.
- busy rises the cycle after start is sampled. done rises the cycle after the last write (no macro) or after the checksum capture (macro).
- Pin protocol: byte_valid high ≥3 clk and low ≥3 clk. byte_in stable for the whole high phase.
- Reset mid-load aborts immediately: mem_we drops and already-written memory words are not undone.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the M data words, one extra word is expected and compared with the N-bit modular sum of all M words.
  - checksum_err is latched at DONE entry.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no accumulator; DONE follows the M-th write.
  - checksum_err tied to 0.

## Test plan
- Basic fill (M=4, N=8): start, then strobes with 0x11, 0x22, 0x33, 0x44 → writes addr0..3 = 0x11..0x44, one mem_we each, 3 cycles after each pin rise. done=1 after the last write (no macro).
- Ignored edges: strobes before start and after done → no mem_we, mem_addr/mem_data unchanged.
- Restart mid-load: 2 words written, then start, then 4 words 0xA0..0xA3 → addr0..3 = 0xA0..0xA3, done=1.
- Start collides with edge in the same cycle → word dropped, counter=0, next strobe written at addr0.
- Checksum (macro, M=4): words 0x01, 0x02, 0x03, 0x04, then 0x0A → checksum_err=0, done=1. Repeat with trailer 0x0B → checksum_err=1.
- Async reset during LOAD after 2 writes → all outputs 0 within the same cycle, state IDLE, busy=0. Later strobes produce no writes until start.
